// File: rtl/systolic_array_gemm_if.sv
// systolic_array_gemm_if: bank write/read, control state and address-window bundle for systolic_array_gemm (master = sequencer, slave = array)
interface systolic_array_gemm_if #(
  parameter int NUM_ROW = 4,
  parameter int NUM_COL = 4,
  parameter int DATA_WIDTH = 16,
  parameter int OUT_DATA_WIDTH = 16,
  parameter int LOG2_SRAM_BANK_DEPTH = 4,
  parameter int CTRL_WIDTH = 4
);
  logic                                i_top_wr_en;
  logic [LOG2_SRAM_BANK_DEPTH-1:0]     i_top_wr_addr;
  logic [NUM_COL*DATA_WIDTH-1:0]       i_top_wr_data;
  logic                                i_left_wr_en;
  logic [LOG2_SRAM_BANK_DEPTH-1:0]     i_left_wr_addr;
  logic [NUM_ROW*DATA_WIDTH-1:0]       i_left_wr_data;
  logic                                i_down_rd_en;
  logic [LOG2_SRAM_BANK_DEPTH-1:0]     i_down_rd_addr;
  logic [NUM_COL*OUT_DATA_WIDTH-1:0]   o_down_rd_data;
  logic [CTRL_WIDTH-1:0]               i_ctrl_state;
  logic [LOG2_SRAM_BANK_DEPTH-1:0]     i_top_sram_rd_start_addr;
  logic [LOG2_SRAM_BANK_DEPTH-1:0]     i_top_sram_rd_end_addr;
  logic [LOG2_SRAM_BANK_DEPTH-1:0]     i_left_sram_rd_start_addr;
  logic [LOG2_SRAM_BANK_DEPTH-1:0]     i_left_sram_rd_end_addr;
  logic [LOG2_SRAM_BANK_DEPTH-1:0]     i_down_sram_rd_start_addr;
  logic [LOG2_SRAM_BANK_DEPTH-1:0]     i_down_sram_rd_end_addr;
  modport master (
    output i_top_wr_en, i_top_wr_addr, i_top_wr_data,
    output i_left_wr_en, i_left_wr_addr, i_left_wr_data,
    output i_down_rd_en, i_down_rd_addr, i_ctrl_state,
    output i_top_sram_rd_start_addr, i_top_sram_rd_end_addr,
    output i_left_sram_rd_start_addr, i_left_sram_rd_end_addr,
    output i_down_sram_rd_start_addr, i_down_sram_rd_end_addr,
    input  o_down_rd_data
  );
  modport slave (
    input  i_top_wr_en, i_top_wr_addr, i_top_wr_data,
    input  i_left_wr_en, i_left_wr_addr, i_left_wr_data,
    input  i_down_rd_en, i_down_rd_addr, i_ctrl_state,
    input  i_top_sram_rd_start_addr, i_top_sram_rd_end_addr,
    input  i_left_sram_rd_start_addr, i_left_sram_rd_end_addr,
    input  i_down_sram_rd_start_addr, i_down_sram_rd_end_addr,
    output o_down_rd_data
  );
endinterface

// File: rtl/systolic_array_gemm.sv
// systolic_array_gemm: output-stationary GEMM array with top/left/down banks; ports clk, rst_n, bus (slave); SYSTOLIC_SAT_ACCU_EN selects saturating accumulation
module systolic_array_gemm #(
  parameter int NUM_ROW = 4,
  parameter int NUM_COL = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACCU_DATA_WIDTH = 16,
  parameter int OUT_DATA_WIDTH = ACCU_DATA_WIDTH,
  parameter int LOG2_SRAM_BANK_DEPTH = 4,
  parameter int SRAM_BANK_DEPTH = 16,
  parameter int CTRL_WIDTH = 4,
  parameter int SKEW_TOP_INPUT_EN = 1
) (
  input logic clk,
  input logic rst_n,
  systolic_array_gemm_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int ACW = ACCU_DATA_WIDTH;
  localparam int OW = OUT_DATA_WIDTH;
  localparam int AW = LOG2_SRAM_BANK_DEPTH;
  localparam int PW = 2 * DW;
  localparam int SW = (PW > ACW ? PW : ACW) + 1;
  localparam int DCW = $clog2(NUM_ROW + 1);
  logic w_warm, w_steady, w_drain;
  assign w_warm = bus.i_ctrl_state == CTRL_WIDTH'(1);
  assign w_steady = bus.i_ctrl_state == CTRL_WIDTH'(2);
  assign w_drain = bus.i_ctrl_state == CTRL_WIDTH'(3);
  logic [NUM_COL*DW-1:0] r_top_mem [SRAM_BANK_DEPTH];
  logic [NUM_ROW*DW-1:0] r_left_mem [SRAM_BANK_DEPTH];
  logic [NUM_COL*OW-1:0] r_down_mem [SRAM_BANK_DEPTH];
  logic [NUM_COL*DW-1:0] r_top_rd;
  logic [NUM_ROW*DW-1:0] r_left_rd;
  logic [AW-1:0] r_top_ptr, r_left_ptr;
  logic r_rd_act;
  logic [NUM_COL*OW-1:0] w_row [NUM_ROW];
  logic [DCW-1:0] r_dcnt;
  logic [AW-1:0] w_off, w_dr_addr;
  logic w_dr_wr;
  // drain row r_dcnt goes to down_start+r_dcnt unless that lies past down_end (modulo window length)
  assign w_off = AW'(r_dcnt);
  assign w_dr_addr = bus.i_down_sram_rd_start_addr + w_off;
  assign w_dr_wr = w_drain && r_dcnt < DCW'(NUM_ROW) &&
                   w_off <= bus.i_down_sram_rd_end_addr - bus.i_down_sram_rd_start_addr;
  always_ff @(posedge clk) begin
    if (bus.i_top_wr_en) r_top_mem[bus.i_top_wr_addr] <= bus.i_top_wr_data;
    if (bus.i_left_wr_en) r_left_mem[bus.i_left_wr_addr] <= bus.i_left_wr_data;
    if (w_dr_wr) r_down_mem[w_dr_addr] <= w_row[r_dcnt];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dcnt <= '0;
      bus.o_down_rd_data <= '0;
    end else begin
      r_dcnt <= !w_drain ? '0 : r_dcnt == DCW'(NUM_ROW) ? r_dcnt : r_dcnt + 1'b1;
      if (bus.i_down_rd_en) bus.o_down_rd_data <= r_down_mem[bus.i_down_rd_addr];
    end
  end
  // operand streaming: the top window length sets K for both banks; zeros follow the last word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_top_ptr <= '0;
      r_left_ptr <= '0;
      r_rd_act <= 1'b0;
      r_top_rd <= '0;
      r_left_rd <= '0;
    end else if (w_warm) begin
      r_top_ptr <= bus.i_top_sram_rd_start_addr;
      r_left_ptr <= bus.i_left_sram_rd_start_addr;
      r_rd_act <= 1'b1;
      r_top_rd <= '0;
      r_left_rd <= '0;
    end else if (w_steady) begin
      r_top_rd <= r_rd_act ? r_top_mem[r_top_ptr] : '0;
      r_left_rd <= r_rd_act ? r_left_mem[r_left_ptr] : '0;
      if (r_rd_act) begin
        r_top_ptr <= r_top_ptr + 1'b1;
        r_left_ptr <= r_left_ptr + 1'b1;
        if (r_top_ptr == bus.i_top_sram_rd_end_addr) r_rd_act <= 1'b0;
      end
    end
  end
  logic signed [DW-1:0] w_a_in [NUM_ROW];
  logic signed [DW-1:0] w_b_in [NUM_COL];
  for (genvar r = 0; r < NUM_ROW; r++) begin : g_l
    logic signed [DW-1:0] w_lane;
    assign w_lane = r_left_rd[r*DW +: DW];
    if (r == 0) begin : g_n
      assign w_a_in[r] = w_lane;
    end else begin : g_d
      logic signed [DW-1:0] r_sk [r];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < r; i++) r_sk[i] <= '0;
        end else if (w_warm) begin
          for (int i = 0; i < r; i++) r_sk[i] <= '0;
        end else if (w_steady) begin
          r_sk[0] <= w_lane;
          for (int i = 1; i < r; i++) r_sk[i] <= r_sk[i-1];
        end
      end
      assign w_a_in[r] = r_sk[r-1];
    end
  end
  for (genvar c = 0; c < NUM_COL; c++) begin : g_t
    localparam int D = SKEW_TOP_INPUT_EN != 0 ? c : 0;
    logic signed [DW-1:0] w_lane;
    assign w_lane = r_top_rd[c*DW +: DW];
    if (D == 0) begin : g_n
      assign w_b_in[c] = w_lane;
    end else begin : g_d
      logic signed [DW-1:0] r_sk [D];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < D; i++) r_sk[i] <= '0;
        end else if (w_warm) begin
          for (int i = 0; i < D; i++) r_sk[i] <= '0;
        end else if (w_steady) begin
          r_sk[0] <= w_lane;
          for (int i = 1; i < D; i++) r_sk[i] <= r_sk[i-1];
        end
      end
      assign w_b_in[c] = r_sk[D-1];
    end
  end
  logic signed [DW-1:0] r_a [NUM_ROW][NUM_COL];
  logic signed [DW-1:0] r_b [NUM_ROW][NUM_COL];
  logic signed [DW-1:0] w_a [NUM_ROW][NUM_COL];
  logic signed [DW-1:0] w_b [NUM_ROW][NUM_COL];
  logic signed [ACW-1:0] r_acc [NUM_ROW][NUM_COL];
  logic signed [ACW-1:0] w_nxt [NUM_ROW][NUM_COL];
  for (genvar r = 0; r < NUM_ROW; r++) begin : g_r
    for (genvar c = 0; c < NUM_COL; c++) begin : g_c
      logic signed [PW-1:0] w_p;
      logic signed [SW-1:0] w_s;
      if (c == 0) begin : g_a0
        assign w_a[r][c] = w_a_in[r];
      end else begin : g_an
        assign w_a[r][c] = r_a[r][c-1];
      end
      if (r == 0) begin : g_b0
        assign w_b[r][c] = w_b_in[c];
      end else begin : g_bn
        assign w_b[r][c] = r_b[r-1][c];
      end
      assign w_p = w_a[r][c] * w_b[r][c];
      assign w_s = w_p + r_acc[r][c];
`ifdef SYSTOLIC_SAT_ACCU_EN
      localparam logic signed [SW-1:0] SMAX = {{(SW-ACW+1){1'b0}}, {(ACW-1){1'b1}}};
      localparam logic signed [SW-1:0] SMIN = ~SMAX;
      assign w_nxt[r][c] = w_s > SMAX ? ACW'(SMAX) : w_s < SMIN ? ACW'(SMIN) : ACW'(w_s);
`else
      assign w_nxt[r][c] = ACW'(w_s);
`endif
      assign w_row[r][c*OW +: OW] = OW'(r_acc[r][c]);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ROW; i++)
        for (int j = 0; j < NUM_COL; j++) begin
          r_a[i][j] <= '0;
          r_b[i][j] <= '0;
          r_acc[i][j] <= '0;
        end
    end else if (w_warm) begin
      for (int i = 0; i < NUM_ROW; i++)
        for (int j = 0; j < NUM_COL; j++) begin
          r_a[i][j] <= '0;
          r_b[i][j] <= '0;
          r_acc[i][j] <= '0;
        end
    end else if (w_steady) begin
      for (int i = 0; i < NUM_ROW; i++)
        for (int j = 0; j < NUM_COL; j++) begin
          r_a[i][j] <= w_a[i][j];
          r_b[i][j] <= w_b[i][j];
          r_acc[i][j] <= w_nxt[i][j];
        end
    end
  end
endmodule

// File: tb/tb_systolic_array_gemm.sv
// tb_systolic_array_gemm: directed checks of identity, all-ones, overflow, drain window, read latency and async reset
module tb_systolic_array_gemm;
  localparam int NR = 4;
  localparam int NC = 4;
  localparam int DW = 16;
  localparam int OW = 16;
  localparam int AW = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  systolic_array_gemm_if #(.NUM_ROW(NR), .NUM_COL(NC), .DATA_WIDTH(DW), .OUT_DATA_WIDTH(OW),
    .LOG2_SRAM_BANK_DEPTH(AW), .CTRL_WIDTH(4)) bus ();
  systolic_array_gemm #(.NUM_ROW(NR), .NUM_COL(NC), .DATA_WIDTH(DW), .ACCU_DATA_WIDTH(16),
    .OUT_DATA_WIDTH(OW), .LOG2_SRAM_BANK_DEPTH(AW), .SRAM_BANK_DEPTH(16), .CTRL_WIDTH(4),
    .SKEW_TOP_INPUT_EN(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic chk(input string tag, input logic [NC*OW-1:0] got, input logic [NC*OW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [NC*OW-1:0] row4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction
  task automatic wr(input logic [AW-1:0] a, input logic [NC*DW-1:0] t, input logic [NR*DW-1:0] l);
    bus.i_top_wr_en = 1'b1;
    bus.i_left_wr_en = 1'b1;
    bus.i_top_wr_addr = a;
    bus.i_left_wr_addr = a;
    bus.i_top_wr_data = t;
    bus.i_left_wr_data = l;
    tick();
    bus.i_top_wr_en = 1'b0;
    bus.i_left_wr_en = 1'b0;
  endtask
  task automatic load_ident;
    logic [NC*DW-1:0] t;
    logic [NR*DW-1:0] l;
    for (int k = 0; k < 4; k++) begin
      t = '0;
      l = '0;
      t[k*DW +: DW] = 16'd1;
      for (int r = 0; r < NR; r++) l[r*DW +: DW] = 16'(4*r + k + 1);
      wr(AW'(k), t, l);
    end
  endtask
  task automatic run(input logic [AW-1:0] s, input logic [AW-1:0] e, input int n);
    bus.i_top_sram_rd_start_addr = s;
    bus.i_top_sram_rd_end_addr = e;
    bus.i_left_sram_rd_start_addr = s;
    bus.i_left_sram_rd_end_addr = e;
    bus.i_ctrl_state = 4'd1;
    tick();
    bus.i_ctrl_state = 4'd2;
    repeat (n) tick();
    bus.i_ctrl_state = 4'd0;
  endtask
  task automatic drain(input logic [AW-1:0] s, input logic [AW-1:0] e);
    bus.i_down_sram_rd_start_addr = s;
    bus.i_down_sram_rd_end_addr = e;
    bus.i_ctrl_state = 4'd3;
    repeat (NR) tick();
    bus.i_ctrl_state = 4'd0;
    tick();
  endtask
  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [NC*OW-1:0] exp);
    bus.i_down_rd_en = 1'b1;
    bus.i_down_rd_addr = a;
    tick();
    bus.i_down_rd_en = 1'b0;
    chk(tag, bus.o_down_rd_data, exp);
  endtask
  initial begin
    logic [NC*OW-1:0] ovf;
`ifdef SYSTOLIC_SAT_ACCU_EN
    ovf = {4{16'h7fff}};
`else
    ovf = '0;
`endif
    bus.i_top_wr_en = 1'b0;
    bus.i_top_wr_addr = '0;
    bus.i_top_wr_data = '0;
    bus.i_left_wr_en = 1'b0;
    bus.i_left_wr_addr = '0;
    bus.i_left_wr_data = '0;
    bus.i_down_rd_en = 1'b0;
    bus.i_down_rd_addr = '0;
    bus.i_ctrl_state = 4'd0;
    bus.i_top_sram_rd_start_addr = '0;
    bus.i_top_sram_rd_end_addr = '0;
    bus.i_left_sram_rd_start_addr = '0;
    bus.i_left_sram_rd_end_addr = '0;
    bus.i_down_sram_rd_start_addr = '0;
    bus.i_down_sram_rd_end_addr = '0;
    repeat (2) tick();
    chk("reset_out", bus.o_down_rd_data, '0);
    rst_n = 1'b1;
    tick();
    load_ident();
    run(4'd0, 4'd3, 11);
    drain(4'd0, 4'd3);
    for (int r = 0; r < 4; r++) rd_chk("ident", AW'(r), row4(4*r+1, 4*r+2, 4*r+3, 4*r+4));
    drain(4'd4, 4'd7);
    rd_chk("redrain4", 4'd4, row4(1, 2, 3, 4));
    for (int k = 8; k < 12; k++) wr(AW'(k), {4{16'd1}}, {4{16'd1}});
    run(4'd8, 4'd11, 11);
    drain(4'd2, 4'd3);
    rd_chk("win_a0", 4'd0, row4(1, 2, 3, 4));
    rd_chk("win_a1", 4'd1, row4(5, 6, 7, 8));
    rd_chk("ones_a2", 4'd2, row4(4, 4, 4, 4));
    rd_chk("ones_a3", 4'd3, row4(4, 4, 4, 4));
    rd_chk("win_a4", 4'd4, row4(1, 2, 3, 4));
    rd_chk("win_a5", 4'd5, row4(5, 6, 7, 8));
    bus.i_down_rd_en = 1'b1;
    bus.i_down_rd_addr = 4'd2;
    #1;
    chk("lat_pre", bus.o_down_rd_data, row4(5, 6, 7, 8));
    tick();
    bus.i_down_rd_en = 1'b0;
    bus.i_down_rd_addr = 4'd0;
    chk("lat_1", bus.o_down_rd_data, row4(4, 4, 4, 4));
    repeat (2) tick();
    chk("lat_hold", bus.o_down_rd_data, row4(4, 4, 4, 4));
    wr(4'd5, {4{16'h0100}}, {4{16'h0100}});
    run(4'd5, 4'd5, 8);
    drain(4'd0, 4'd3);
    rd_chk("ovf_a0", 4'd0, ovf);
    rd_chk("ovf_a3", 4'd3, ovf);
    rd_chk("pre_rst", 4'd4, row4(1, 2, 3, 4));
    load_ident();
    bus.i_top_sram_rd_start_addr = 4'd0;
    bus.i_top_sram_rd_end_addr = 4'd3;
    bus.i_left_sram_rd_start_addr = 4'd0;
    bus.i_left_sram_rd_end_addr = 4'd3;
    bus.i_ctrl_state = 4'd1;
    tick();
    bus.i_ctrl_state = 4'd2;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", bus.o_down_rd_data, '0);
    bus.i_ctrl_state = 4'd0;
    tick();
    rst_n = 1'b1;
    tick();
    load_ident();
    run(4'd0, 4'd3, 11);
    drain(4'd0, 4'd3);
    rd_chk("rerun_a2", 4'd2, row4(9, 10, 11, 12));
    rd_chk("rerun_a0", 4'd0, row4(1, 2, 3, 4));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
